// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding, ACK polarity and bit-counter width for the I2C byte writer
package i2c_pkg;
  typedef enum logic [3:0] {IDLE, START, HOLD, ADDR, ACK1, DATA, ACK2, STOP, STOP2} state_t;
  localparam logic ACK = 1'b0;
  localparam logic NACK = 1'b1;
  localparam int CNT_W = 3;
endpackage

// File: rtl/i2c_edge_sync.sv
// i2c_edge_sync: synchronises ClockI2C and SDAIn and derives one-cycle rise/fall pulses
module i2c_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_s,
  output logic sda_s,
  output logic rise,
  output logic fall
);
  logic [SYNC_STAGES:0] c;
  logic [SYNC_STAGES-1:0] d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      c <= '0;
      d <= '1;
    end else begin
      c <= {c[SYNC_STAGES-1:0], scl_in};
      d <= {d[SYNC_STAGES-2:0], sda_in};
    end
  assign scl_s = c[SYNC_STAGES-1];
  assign sda_s = d[SYNC_STAGES-1];
  assign rise = c[SYNC_STAGES-1] & ~c[SYNC_STAGES];
  assign fall = ~c[SYNC_STAGES-1] & c[SYNC_STAGES];
endmodule

// File: rtl/i2c_byte_writer.sv
// i2c_byte_writer: frames START, address+RW, ACK, one data byte, ACK and STOP from ClockI2C edges
module i2c_byte_writer
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       Reset,
  input  logic       Start,
  input  logic [6:0] SlaveAddress,
  input  logic       RW,
  input  logic [7:0] DataIn,
  input  logic       ClockI2C,
  input  logic       SDAIn,
  output logic       BaudEnable,
  output logic       SCL,
  output logic       SDADriveLow,
  output logic       Busy,
  output logic       Done,
  output logic       AckError
);
  state_t state;
  logic [7:0] shift, data;
  logic [CNT_W-1:0] cnt;
  logic rw, follow, ack_bit;
  logic scl_s, sda_s, rise_r, fall_r, rise, fall;
  i2c_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clock), .rst_n(Reset), .scl_in(ClockI2C), .sda_in(SDAIn),
    .scl_s(scl_s), .sda_s(sda_s), .rise(rise_r), .fall(fall_r)
  );
  assign rise = rise_r & BaudEnable;
  assign fall = fall_r & BaudEnable;
  always_ff @(posedge clock or negedge Reset)
    if (!Reset) begin
      state <= IDLE;
      SCL <= 1'b1;
      SDADriveLow <= 1'b0;
      BaudEnable <= 1'b0;
      Busy <= 1'b0;
      Done <= 1'b0;
      AckError <= 1'b0;
      follow <= 1'b0;
      ack_bit <= ACK;
      shift <= '0;
      data <= '0;
      rw <= 1'b0;
      cnt <= '0;
    end else begin
      Done <= 1'b0;
      SCL <= follow ? scl_s : 1'b1;
      case (state)
        IDLE: if (Start) begin
          shift <= {SlaveAddress, RW};
          data <= DataIn;
          rw <= RW;
          AckError <= 1'b0;
          BaudEnable <= 1'b1;
          Busy <= 1'b1;
          state <= START;
        end
        START: if (rise) begin
          SDADriveLow <= 1'b1;
          state <= HOLD;
        end
        HOLD: if (fall) begin
          follow <= 1'b1;
          SCL <= scl_s;
          SDADriveLow <= ~shift[7];
          cnt <= '1;
          state <= ADDR;
        end
        ADDR, DATA: if (fall) begin
          if (cnt == '0) begin
            SDADriveLow <= 1'b0;
            state <= (state == ADDR) ? ACK1 : ACK2;
          end else begin
            shift <= shift << 1;
            cnt <= cnt - 1'b1;
            SDADriveLow <= ~shift[6];
          end
        end
        ACK1, ACK2: if (rise) begin
          ack_bit <= sda_s;
          if (sda_s == NACK) AckError <= 1'b1;
        end else if (fall) begin
          if (state == ACK2 || rw || ack_bit == NACK) begin
            SDADriveLow <= 1'b1;
            state <= STOP;
          end else begin
            shift <= data;
            SDADriveLow <= ~data[7];
            cnt <= '1;
            state <= DATA;
          end
        end
        STOP: if (rise) begin
          follow <= 1'b0;
          SCL <= 1'b1;
          state <= STOP2;
        end
        STOP2: if (fall) begin
          SDADriveLow <= 1'b0;
          BaudEnable <= 1'b0;
          Busy <= 1'b0;
          Done <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: doc/i2c_byte_writer.md
Name: i2c_byte_writer

Overview:
- I2C master write framer that sits directly downstream of the baud rate generator and consumes its ClockI2C output.
- On a Start request it enables the generator and emits a START condition, then the 7-bit slave address plus the R/W bit, then an ACK slot.
- It then emits one data byte, an ACK slot and a STOP condition.
- SCL is derived from ClockI2C; SDA is open-drain, driven low through SDADriveLow.

Parameters:
- SYNC_STAGES, 2: number of flops used to synchronise ClockI2C and SDAIn into the clock domain (minimum 2).

Ports:
- clock  input  1  system clock; all state on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  one-cycle request; accepted only in IDLE.
- SlaveAddress  input  7  latched on accepted Start.
- RW  input  1  latched on accepted Start; 1 = read request.
- DataIn  input  8  latched on accepted Start.
- ClockI2C  input  1  output of the baud rate generator.
- SDAIn  input  1  SDA line value, used for ACK sampling.
- BaudEnable  output  1  drives the generator's Enable input.
- SCL  output  1  I2C clock.
- SDADriveLow  output  1  1 = pull SDA low; 0 = release the line.
- Busy  output  1  high while a frame is in progress.
- Done  output  1  one-cycle completion pulse.
- AckError  output  1  sticky NACK flag; cleared on the next accepted Start.

Behaviour:
- Reset (Reset=0, immediate):
  - state = IDLE, SCL=1, SDADriveLow=0.
  - BaudEnable=0, Busy=0, Done=0, AckError=0.
  - Latched registers are cleared.
  - Reset mid-frame aborts with no STOP generated.
- Edge events:
  - ClockI2C passes through SYNC_STAGES flops; rise and fall are one-cycle pulses from comparing the last two synchronised samples.
  - Edges are only observed while BaudEnable=1.
- IDLE:
  - SCL=1, SDA released.
  - Start=1 latches the shift register = {SlaveAddress,RW}, data byte and RW; clears AckError; sets BaudEnable=1 and Busy=1; goes to START.
- START: on rise, SDADriveLow=1 (SDA falls while SCL high); go to HOLD.
- HOLD: on fall, SCL begins to follow the synchronised ClockI2C; drive shift MSB; bit counter = 7; go to ADDR.
- ADDR:
  - SCL follows ClockI2C. Bit value 0 -> SDADriveLow=1; bit value 1 -> 0.
  - On each fall, shift left and decrement.
  - On the fall after bit 0's high phase, release SDA and go to ACK1.
- ACK1:
  - On rise, sample synchronised SDAIn; 1 = NACK and sets AckError.
  - On fall:
    - NACK or RW=1: SDADriveLow=1, go to STOP.
    - Otherwise: load the data byte, drive its MSB, counter = 7, go to DATA.
- DATA: identical to ADDR; exits to ACK2.
- ACK2: sample on rise as in ACK1; on fall, SDADriveLow=1 and go to STOP.
- STOP: on rise, SCL is held at 1 and no longer follows; go to STOP2.
- STOP2:
  - On the next fall, SDADriveLow=0 (SDA rises while SCL high), BaudEnable=0, Busy=0; go to IDLE.
  - Done=1 for exactly the first IDLE cycle.
  - A Start in that same cycle is accepted.
- SDA changes only in cycles where SCL is low, except at START and STOP.
- Start while Busy=1 is ignored; input changes mid-frame do not affect the frame.
- rise and fall are never simultaneous. Any edge event not listed for the current state is ignored.
- Frame length:
  - Full write: 18 SCL high pulses (9 per byte) plus a final SCL high level that carries the STOP.
  - Early stop: 9 pulses plus the STOP level.

Decomposition:
- Package i2c_pkg holds:
  - state encoding constants: IDLE, START, HOLD, ADDR, ACK1, DATA, ACK2, STOP, STOP2;
  - ACK = 0 and NACK = 1;
  - the bit-counter width (3).
- One sub-module, i2c_edge_sync:
  - synchronises ClockI2C and SDAIn (SYNC_STAGES parameter);
  - outputs synchronised levels plus rise and fall pulses;
  - uses the same clock and active-low async reset.

Test Plan:
- Bench setup: clock period 8 ns; ClockI2C driven directly with a 16-clock period, gated by BaudEnable.
- Address 0x50, RW=0, DataIn 0xA5, SDAIn pulled low in both ACK slots -> SDA bits 1010000 0, released, 10100101, released; STOP follows; 18 SCL pulses; Done one cycle; AckError=0.
- Address 0x3C, SDAIn high in the ACK1 slot -> AckError=1; no data bits; STOP right after ACK1; Done pulses; AckError remains 1 until the next Start.
- RW=1, address 0x21, ACK given -> 9 SCL pulses, then STOP; no data byte; AckError=0.
- Start pulsed again, and DataIn changed to 0xFF, during the DATA phase -> both ignored; transmitted byte still 0xA5; one Done only.
- Reset driven low in the middle of DATA -> SCL=1, SDADriveLow=0, BaudEnable=0, Busy=0 asynchronously; the next Start runs a full clean frame.
- Start asserted in the Done cycle -> new frame begins; Busy high on the following cycle; the START condition appears on the next ClockI2C rise.
